// File: rtl/alu32_issue_ctrl_if.sv
// Command and result handshake bundle for alu32_issue_ctrl.
// master = upstream requester, slave = the issue controller.
interface alu32_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2,
    parameter int TAG_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [SEL_W-1:0]  cmd_sel;
    logic [TAG_W-1:0]  cmd_tag;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        output res_ready,
        input  cmd_ready,
        input  res_valid, res_data, res_tag
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        input  res_ready,
        output cmd_ready,
        output res_valid, res_data, res_tag
    );
endinterface

// File: rtl/alu32_issue_ctrl.sv
// Issue controller for the registered ALU: credit-limited issue,
// marker pipe capture, FWFT result FIFO. Optional macro: ALU_TAG_EN.
module alu32_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 2,
    parameter int ALU_LAT = 1,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu32_issue_ctrl_if.slave io,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

    logic [ALU_LAT:0]  mark;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] dmem [DEPTH];
    logic [DATA_W-1:0] last_d;
    logic              accept;
    logic              pop;
    logic              cap;

    // Credits come from registered counts only; rst alone gates them.
    assign io.cmd_ready = !rst &&
        (({1'b0, inflight} + {1'b0, count}) < CAP);

    assign accept = io.cmd_valid && io.cmd_ready;
    assign cap    = mark[ALU_LAT];
    assign io.res_valid = (count != '0);
    assign pop    = io.res_valid && io.res_ready;
    assign busy   = (inflight != '0) || (count != '0);
    assign io.res_data = io.res_valid ? dmem[rd_ptr] : last_d;

    // Next in-flight and FIFO occupancy.
    always_comb begin
        inflight_n = inflight;
        count_n    = count;
        unique case ({accept, cap})
            2'b10:   inflight_n = inflight + CNT_W'(1);
            2'b01:   inflight_n = inflight - CNT_W'(1);
            default: inflight_n = inflight;
        endcase
        unique case ({cap, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
    end

    // Control state, ALU operand registers and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mark     <= '0;
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_d   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
        end else begin
            mark     <= (mark << 1) | (ALU_LAT + 1)'(accept);
            inflight <= inflight_n;
            count    <= count_n;
            if (cap) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_d <= dmem[rd_ptr];
            end
            if (accept) begin
                alu_a   <= io.cmd_a;
                alu_b   <= io.cmd_b;
                alu_sel <= io.cmd_sel;
            end
        end
    end

    // Result storage; the marker pipe decides which ALU outputs count.
    always_ff @(posedge clk) begin
        if (cap && !rst) begin
            dmem[wr_ptr] <= alu_out;
        end
    end

`ifdef ALU_TAG_EN
    logic [TAG_W-1:0] tpipe [ALU_LAT+1];
    logic [TAG_W-1:0] tmem [DEPTH];
    logic [TAG_W-1:0] last_t;

    assign io.res_tag = io.res_valid ? tmem[rd_ptr] : last_t;

    // Tags ride alongside the markers; markers alone qualify them.
    always_ff @(posedge clk) begin
        tpipe[0] <= io.cmd_tag;
        for (int i = 1; i <= ALU_LAT; i++) begin
            tpipe[i] <= tpipe[i-1];
        end
    end

    // Tag storage written in step with the data FIFO.
    always_ff @(posedge clk) begin
        if (cap && !rst) begin
            tmem[wr_ptr] <= tpipe[ALU_LAT];
        end
    end

    // Last popped tag, shown while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_t <= '0;
        end else if (pop) begin
            last_t <= tmem[rd_ptr];
        end
    end
`else
    logic unused_tag;

    assign unused_tag = ^io.cmd_tag;
    assign io.res_tag = '0;
`endif

endmodule

// File: tb/tb_alu32_issue_ctrl.sv
// Directed bench for alu32_issue_ctrl with a queue scoreboard.
// The bench plays a registered one-cycle ALU.
module tb_alu32_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_sel;
    logic [31:0] alu_out = '0;
    logic        busy;

    always #5 clk = ~clk;

    alu32_issue_ctrl_if #(.DATA_W(32), .SEL_W(2), .TAG_W(4)) ifc ();

    alu32_issue_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .io      (ifc),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_out (alu_out),
        .busy    (busy)
    );

    always @(posedge clk) begin
        case (alu_sel)
            2'd0:    alu_out <= alu_a & alu_b;
            2'd1:    alu_out <= alu_a | alu_b;
            2'd2:    alu_out <= ~alu_a;
            default: alu_out <= alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pop_cyc[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   max_occ = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] etag(input logic [3:0] t);
`ifdef ALU_TAG_EN
        return t;
`else
        return 4'h0 & t;
`endif
    endfunction

    // Monitor: pops the scoreboard on every result transfer.
    always @(negedge clk) begin
        if (exp_q.size() > max_occ) max_occ = exp_q.size();
        if (!rst && ifc.res_valid && ifc.res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none",
                         ifc.res_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_data", ifc.res_data, mon_e.d);
                chk("res_tag", {28'b0, ifc.res_tag}, {28'b0, mon_e.t});
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] s, input logic [3:0] tg,
                        input logic [31:0] exp, input bit push,
                        output int acc);
        bit done = 0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        ifc.cmd_sel   = s;
        ifc.cmd_tag   = tg;
        acc = -1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (ifc.cmd_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                if (push) exp_q.push_back('{exp, etag(tg)});
                done = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        ifc.cmd_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        chk(nm, exp_q.size(), 0);
    endtask

    logic [31:0] t3_a [6];
    logic [31:0] t3_e [6];
    logic [31:0] t6_b [11];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int first;
        int idx;
        bit sawv;

        t3_a = '{32'hA5A5_A5A5, 32'hA5A5_A5A4, 32'hA5A5_A5A7,
                 32'hA5A5_A5A6, 32'hA5A5_A5A1, 32'hA5A5_A5A0};
        t3_e = '{32'hA5A5_A5A5, 32'hA5A5_A5A4, 32'hA5A5_A5A7,
                 32'hA5A5_A5A6, 32'hA5A5_A5A1, 32'hA5A5_A5A0};
        for (int i = 0; i < 11; i++) t6_b[i] = 32'h1000_0000 + i;

        rst = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_a     = '0;
        ifc.cmd_b     = '0;
        ifc.cmd_sel   = '0;
        ifc.cmd_tag   = '0;
        ifc.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", ifc.cmd_ready, 0);
        chk("rst_res_valid", ifc.res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_res_data", ifc.res_data, 0);
        chk("rst_res_tag", ifc.res_tag, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ifc.cmd_ready, 1);
        @(posedge clk);
        #1;

        // single op and its latency
        ifc.res_ready = 1'b1;
        send(32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'd0, 4'h1,
             32'h00F0_00F0, 1, acc);
        @(negedge clk);
        chk("t1_valid_e0", ifc.res_valid, 0);
        chk("t1_alu_a", alu_a, 32'hF0F0_F0F0);
        chk("t1_alu_b", alu_b, 32'h0FF0_0FF0);
        @(negedge clk);
        chk("t1_valid_e1", ifc.res_valid, 0);
        @(negedge clk);
        chk("t1_valid_e2", ifc.res_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_busy_idle", busy, 0);
        chk("t1_empty_valid", ifc.res_valid, 0);
        chk("t1_hold_data", ifc.res_data, 32'h00F0_00F0);

        // back-to-back
        pop_cyc.delete();
        send(32'h0000_FFFF, 32'h00FF_00FF, 2'd1, 4'h0,
             32'h00FF_FFFF, 1, acc);
        send(32'h0000_FFFF, 32'h00FF_00FF, 2'd2, 4'h0,
             32'hFFFF_0000, 1, acc);
        send(32'h0000_FFFF, 32'h00FF_00FF, 2'd3, 4'h0,
             32'h00FF_FF00, 1, acc);
        wait_drain("t2_drain");
        chk("t2_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3)
            chk("t2_consecutive", pop_cyc[2] - pop_cyc[0], 2);

        // backpressure: 4 credits
        ifc.res_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 6) begin
                ifc.cmd_valid = 1'b1;
                ifc.cmd_a     = t3_a[idx];
                ifc.cmd_b     = 32'hFFFF_FFFF;
                ifc.cmd_sel   = 2'd0;
                ifc.cmd_tag   = 4'h0;
            end
            @(negedge clk);
            if (ifc.cmd_ready && idx < 6) begin
                @(posedge clk);
                #1;
                exp_q.push_back('{t3_e[idx], 4'h0});
                idx++;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("t3_accepted", idx, 4);
        chk("t3_ready_low", ifc.cmd_ready, 0);
        chk("t3_busy", busy, 1);
        ifc.res_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            ifc.cmd_valid = 1'b1;
            ifc.cmd_a     = t3_a[idx];
            @(negedge clk);
            if (ifc.cmd_ready) begin
                @(posedge clk);
                #1;
                exp_q.push_back('{t3_e[idx], 4'h0});
                idx++;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        ifc.cmd_valid = 1'b0;
        chk("t3_all_accepted", idx, 6);
        wait_drain("t3_drain");

        // reset mid-flight
        send(32'h1234_5678, 32'hFFFF_FFFF, 2'd0, 4'h5, 0, 0, acc);
        send(32'h8765_4321, 32'hFFFF_FFFF, 2'd1, 4'h6, 0, 0, acc);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_ready_in_rst", ifc.cmd_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_valid", ifc.res_valid, 0);
        chk("t4_alu_a", alu_a, 0);
        chk("t4_alu_b", alu_b, 0);
        chk("t4_alu_sel", alu_sel, 0);
        chk("t4_res_data", ifc.res_data, 0);
        chk("t4_res_tag", ifc.res_tag, 0);
        @(negedge clk);
        chk("t4_ready_after", ifc.cmd_ready, 1);
        sawv = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ifc.res_valid) sawv = 1;
        end
        chk("t4_no_result", sawv, 0);
        @(posedge clk);
        #1;

        // tags
        send(32'hFFFF_0000, 32'h0F0F_0F0F, 2'd0, 4'h3,
             32'h0F0F_0000, 1, acc);
        send(32'hFFFF_0000, 32'h0F0F_0F0F, 2'd1, 4'h7,
             32'hFFFF_0F0F, 1, acc);
        send(32'hFFFF_0000, 32'h0F0F_0F0F, 2'd3, 4'hA,
             32'hF0F0_0F0F, 1, acc);
        wait_drain("t5_drain");

        // full boundary: sustained accept+pop at occupancy 3
        ifc.res_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'hFFFF_FFFF, t6_b[i], 2'd0, 4'h0, t6_b[i], 1, acc);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_fifo_valid", ifc.res_valid, 1);
        max_occ = 0;
        ifc.res_ready = 1'b1;
        first = -1;
        for (int i = 3; i < 11; i++) begin
            send(32'hFFFF_FFFF, t6_b[i], 2'd0, 4'h0, t6_b[i], 1, acc);
            if (first < 0) first = acc;
        end
        chk("t6_sustained", acc - first, 7);
        wait_drain("t6_drain");
        chk("t6_max_occ_le4", max_occ <= 4, 1);
        chk("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
